ifetch_unit: RTL and testbench

- Instruction fetch front end. Produces the 32-bit instruction word consumed by the instruction decoder, with the instruction's PC alongside it.
- Fetches sequential words from instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO.
- Restarts at a new PC when the execute stage signals a jump, branch or exception redirect.

---
 rtl/ifetch_unit.sv | 154 +++++++++++++++
 tb/tb_ifetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential word fetch over a req/ack memory port,
// buffered in a small prefetch FIFO, with redirect support from the execute stage.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'hBFC00000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        memReq,
   output logic [31:0] memAddr,
   input  logic        memAck,
   input  logic [31:0] memData,
   output logic [31:0] ins,
   output logic [31:0] pc,
   output logic        insValid,
   input  logic        insTake,
   input  logic        redirect,
   input  logic [31:0] redirectPc
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } FetchState;

   FetchState        state;
   logic [31:0]      fetchPc;
   logic [31:0]      insBuf [FIFO_DEPTH];
   logic [31:0]      pcBuf  [FIFO_DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] countNext;
   logic             push;
   logic             pop;
   logic [31:0]      redirectAligned;
   logic [31:0]      fetchPcInc;

   // A redirect flushes the FIFO and beats both an incoming ack and a decoder pop.
   always_comb begin
      push            = (state == ST_WAIT) && memAck && !redirect;
      pop             = (count != '0) && insTake && !redirect;
      redirectAligned = redirectPc & 32'hFFFF_FFFC;
      fetchPcInc      = fetchPc + 32'd4;
      if (redirect) begin
         countNext = '0;
      end else begin
         countNext = count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Request FSM. A request is only launched when the FIFO can absorb its ack,
   // so the ack path never needs back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         fetchPc <= RESET_PC;
         memReq  <= 1'b0;
         memAddr <= RESET_PC;
      end else begin
         case (state)
            ST_IDLE: begin
               if (redirect) begin
                  fetchPc <= redirectAligned;
               end else if (count < DEPTH_C) begin
                  state   <= ST_WAIT;
                  memReq  <= 1'b1;
                  memAddr <= fetchPc;
               end
            end
            ST_WAIT: begin
               if (memAck && redirect) begin
                  state   <= ST_IDLE;
                  memReq  <= 1'b0;
                  fetchPc <= redirectAligned;
               end else if (memAck) begin
                  fetchPc <= fetchPcInc;
                  if (countNext < DEPTH_C) begin
                     memAddr <= fetchPcInc;
                  end else begin
                     state  <= ST_IDLE;
                     memReq <= 1'b0;
                  end
               end else if (redirect) begin
                  state   <= ST_DROP;
                  fetchPc <= redirectAligned;
               end
            end
            ST_DROP: begin
               if (redirect) begin
                  fetchPc <= redirectAligned;
               end
               if (memAck) begin
                  state  <= ST_IDLE;
                  memReq <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               memReq <= 1'b0;
            end
         endcase
      end
   end

   // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         count <= countNext;
         if (redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
         end else begin
            if (push) begin
               wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
               rdPtr <= rdPtr + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         insBuf[wrPtr] <= memData;
         pcBuf[wrPtr]  <= fetchPc;
      end
   end

   assign insValid = (count != '0);
   assign ins      = insValid ? insBuf[rdPtr] : 32'h0;
   assign pc       = insValid ? pcBuf[rdPtr]  : 32'h0;

   // Design invariants the memory side and decoder depend on.
   ackHasRoom: assert property (@(posedge clk) disable iff (rst)
      push |-> (count < DEPTH_C));
   reqMatchesState: assert property (@(posedge clk) disable iff (rst)
      memReq == (state != ST_IDLE));
   addrAligned: assert property (@(posedge clk) disable iff (rst)
      memAddr[1:0] == 2'b00);
   addrHeldUntilAck: assert property (@(posedge clk) disable iff (rst)
      (memReq && !memAck) |=> $stable(memAddr));

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory responder, directed fetch/redirect
// scenarios, and a monitor that checks every instruction the decoder consumes.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;
   logic [31:0] ins;
   logic [31:0] pc;
   logic        insValid;
   logic        insTake;
   logic        redirect;
   logic [31:0] redirectPc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ExpEntry;

   ExpEntry     expQ[$];
   logic [31:0] ackLog[$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          popCount   = 0;
   int          reqGaps    = 0;
   int          memLat     = 1;
   bit          trackReq   = 1'b0;

   ifetch_unit #(
      .RESET_PC  (32'hBFC00000),
      .FIFO_DEPTH(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .memReq    (memReq),
      .memAddr   (memAddr),
      .memAck    (memAck),
      .memData   (memData),
      .ins       (ins),
      .pc        (pc),
      .insValid  (insValid),
      .insTake   (insTake),
      .redirect  (redirect),
      .redirectPc(redirectPc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h13579BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic take, input logic redir, input logic [31:0] rpc);
      insTake    = take;
      redirect   = redir;
      redirectPc = rpc;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pushExp(input logic [31:0] a);
      ExpEntry e;
      e.pc  = a;
      e.ins = memWord(a);
      expQ.push_back(e);
   endtask

   task automatic waitPops(input int n, input int budget, input string name);
      int target;
      int left;
      target = popCount + n;
      left   = budget;
      while (popCount < target && left > 0) begin
         tick();
         left--;
      end
      checkOutput(name, 32'(popCount >= target), 32'd1);
   endtask

   task automatic waitAck(input int budget, input string name);
      int left;
      left = budget;
      while (!memAck && left > 0) begin
         tick();
         left--;
      end
      checkOutput(name, 32'(memAck), 32'd1);
   endtask

   task automatic waitReqAt(input logic [31:0] addr, input int budget, input string name);
      int left;
      left = budget;
      while (!(memReq && memAddr == addr) && left > 0) begin
         tick();
         left--;
      end
      checkOutput(name, 32'(memReq && memAddr == addr), 32'd1);
   endtask

   task automatic checkAckLog(input int idx, input logic [31:0] expected, input string name);
      if (idx < ackLog.size()) begin
         checkOutput(name, ackLog[idx], expected);
      end else begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL %s: ack #%0d missing, expected %h", name, idx, expected);
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      ticks(2);
      expQ.delete();
      ackLog.delete();
      rst = 1'b0;
   endtask

   // Memory responder: acks memLat cycles after a request first appears.
   initial begin
      int reqAge;
      reqAge  = 0;
      memAck  = 1'b0;
      memData = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !memReq || memAck) begin
            reqAge = 0;
         end
         if (!rst && memReq && reqAge >= memLat) begin
            memAck  = 1'b1;
            memData = memWord(memAddr);
            ackLog.push_back(memAddr);
         end else begin
            memAck = 1'b0;
            if (!rst && memReq) begin
               reqAge++;
            end
         end
      end
   end

   // Monitor: every instruction the decoder takes must be the next expected one.
   initial begin
      ExpEntry e;
      forever begin
         @(negedge clk);
         if (!rst && insValid && insTake && !redirect) begin
            popCount++;
            if (expQ.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpectedPop: got pc %h ins %h, expected no entry", pc, ins);
            end else begin
               e = expQ.pop_front();
               checkOutput("popPc", pc, e.pc);
               checkOutput("popIns", ins, e.ins);
            end
         end
         if (trackReq && !memReq) begin
            reqGaps++;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, %0d errors so far", errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      #3 rst = 1'b1;
      tick();

      // Reset state
      checkOutput("rstMemReq", 32'(memReq), 32'd0);
      checkOutput("rstMemAddr", memAddr, 32'hBFC00000);
      checkOutput("rstInsValid", 32'(insValid), 32'd0);
      checkOutput("rstIns", ins, 32'h0);
      checkOutput("rstPc", pc, 32'h0);

      // Streaming fetch with a 1-cycle memory and a decoder that always takes
      $display("[TB] streaming fetch");
      memLat = 1;
      expQ.delete();
      ackLog.delete();
      for (int i = 0; i < 8; i++) pushExp(32'hBFC00000 + 32'(4 * i));
      applyStimulus(1'b1, 1'b0, 32'h0);
      rst = 1'b0;
      waitAck(20, "t1FirstAck");
      trackReq = 1'b1;
      reqGaps  = 0;
      tick();
      checkOutput("t1ValidAfterAck", 32'(insValid), 32'd1);
      checkOutput("t1FirstPc", pc, 32'hBFC00000);
      waitPops(8, 100, "t1Pops");
      trackReq = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t1ReqGaps", 32'(reqGaps), 32'd0);
      for (int i = 0; i < 8; i++) checkAckLog(i, 32'hBFC00000 + 32'(4 * i), "t1Addr");

      // FIFO fills and stops fetching; a single take frees one slot
      $display("[TB] fill and single take");
      doReset();
      memLat = 0;
      ticks(10);
      checkOutput("t2AckCount", 32'(ackLog.size()), 32'd2);
      checkAckLog(0, 32'hBFC00000, "t2Addr0");
      checkAckLog(1, 32'hBFC00004, "t2Addr1");
      checkOutput("t2ReqIdle", 32'(memReq), 32'd0);
      checkOutput("t2Valid", 32'(insValid), 32'd1);
      checkOutput("t2HeadPc", pc, 32'hBFC00000);
      pushExp(32'hBFC00000);
      applyStimulus(1'b1, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      ticks(10);
      checkOutput("t2AckCount2", 32'(ackLog.size()), 32'd3);
      checkAckLog(2, 32'hBFC00008, "t2Addr2");
      checkOutput("t2NewHeadPc", pc, 32'hBFC00004);
      checkOutput("t2ReqIdle2", 32'(memReq), 32'd0);

      // Redirect while a slow request is outstanding
      $display("[TB] redirect with outstanding request");
      doReset();
      memLat = 3;
      waitReqAt(32'hBFC00004, 30, "t3ReqSeen");
      applyStimulus(1'b0, 1'b1, 32'h80000100);
      expQ.delete();
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t3DropReq", 32'(memReq), 32'd1);
      checkOutput("t3Flushed", 32'(insValid), 32'd0);
      begin
         int left;
         left = 10;
         while (!memAck && left > 0) begin
            checkOutput("t3HoldAddr", memAddr, 32'hBFC00004);
            tick();
            left--;
         end
      end
      checkOutput("t3AckSeen", 32'(memAck), 32'd1);
      checkOutput("t3AckAddr", memAddr, 32'hBFC00004);
      pushExp(32'h80000100);
      pushExp(32'h80000104);
      applyStimulus(1'b1, 1'b0, 32'h0);
      waitPops(2, 60, "t3Pops");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAckLog(0, 32'hBFC00000, "t3Addr0");
      checkAckLog(1, 32'hBFC00004, "t3Addr1");
      checkAckLog(2, 32'h80000100, "t3Addr2");
      checkAckLog(3, 32'h80000104, "t3Addr3");

      // Redirect in the same cycle as an ack, unaligned target
      $display("[TB] redirect coinciding with ack");
      doReset();
      memLat = 2;
      waitAck(20, "t4Ack");
      applyStimulus(1'b0, 1'b1, 32'h80000203);
      expQ.delete();
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t4Flushed", 32'(insValid), 32'd0);
      checkOutput("t4ReqIdle", 32'(memReq), 32'd0);
      tick();
      checkOutput("t4NewReq", 32'(memReq), 32'd1);
      checkOutput("t4NewAddr", memAddr, 32'h80000200);
      pushExp(32'h80000200);
      pushExp(32'h80000204);
      applyStimulus(1'b1, 1'b0, 32'h0);
      waitPops(2, 60, "t4Pops");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAckLog(0, 32'hBFC00000, "t4Addr0");
      checkAckLog(1, 32'h80000200, "t4Addr1");

      // Redirect and take together with a full FIFO
      $display("[TB] redirect with take on full FIFO");
      doReset();
      memLat = 0;
      ticks(8);
      checkOutput("t5Full", 32'(insValid), 32'd1);
      checkOutput("t5HeadPc", pc, 32'hBFC00000);
      checkOutput("t5ReqIdle", 32'(memReq), 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h80001000);
      expQ.delete();
      ackLog.delete();
      tick();
      checkOutput("t5Flushed", 32'(insValid), 32'd0);
      checkOutput("t5EmptyPc", pc, 32'h0);
      checkOutput("t5EmptyIns", ins, 32'h0);
      pushExp(32'h80001000);
      pushExp(32'h80001004);
      applyStimulus(1'b1, 1'b0, 32'h0);
      waitPops(2, 60, "t5Pops");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAckLog(0, 32'h80001000, "t5Addr0");

      // Asynchronous reset in the middle of an outstanding request
      $display("[TB] async reset mid-request");
      doReset();
      memLat = 3;
      waitReqAt(32'hBFC00004, 30, "t6ReqSeen");
      checkOutput("t6PreValid", 32'(insValid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("t6MemReq", 32'(memReq), 32'd0);
      checkOutput("t6InsValid", 32'(insValid), 32'd0);
      checkOutput("t6Ins", ins, 32'h0);
      checkOutput("t6Pc", pc, 32'h0);
      checkOutput("t6MemAddr", memAddr, 32'hBFC00000);
      ticks(2);
      expQ.delete();
      ackLog.delete();
      pushExp(32'hBFC00000);
      pushExp(32'hBFC00004);
      applyStimulus(1'b1, 1'b0, 32'h0);
      rst = 1'b0;
      waitPops(2, 60, "t6Pops");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkAckLog(0, 32'hBFC00000, "t6Addr0");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
